// File: rtl/nbyone_mux_pkg.sv
// Shared mode encodings and the width helper used by the N-to-1 channel multiplexer.
// Imported by the interface, the arbiter and the top module.
package nbyone_mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Smallest r with 2**r >= n; used to size channel indices.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/nbyone_mux_rr_if.sv
// Channel-side and consumer-side handshake bundle of the N-to-1 multiplexer.
// master = producers/consumer environment, slave = the multiplexer itself.
interface nbyone_mux_rr_if
    import nbyone_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
);
    localparam int SEL_W = clog2(NUM_CH);

    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [DATA_W-1:0]        out_data;
    logic [SEL_W-1:0]         out_ch;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_parity;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid, out_parity
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid, out_parity
    );

endinterface

// File: rtl/nbyone_mux_rr_arb.sv
// Stateless rotating-priority arbiter: grants the first requester at or after ptr,
// wrapping modulo NUM_CH. The pointer itself is owned by the caller.
module nbyone_mux_rr_arb
    import nbyone_mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              gnt_vld,
    output logic [SEL_W-1:0]  gnt_idx
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = SEL_W'((32'(ptr) + 32'(i)) % 32'(NUM_CH));
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/nbyone_mux_rr.sv
// N-to-1 valid/ready channel multiplexer with registered output; select or round-robin mode.
// Optional even-parity output register enabled by defining NBYONE_MUX_PARITY_EN.
module nbyone_mux_rr
    import nbyone_mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = clog2(NUM_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    nbyone_mux_rr_if.slave   bus
);

    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_ch_q,   out_ch_d;
    logic              out_valid_q, out_valid_d;
    logic [SEL_W-1:0]  rr_ptr_q,   rr_ptr_d;

    logic              load_en;
    logic              sel_ok;
    logic              arb_vld;
    logic [SEL_W-1:0]  arb_idx;
    logic              gnt_vld;
    logic [SEL_W-1:0]  gnt_idx;
    logic              xfer;
    logic [DATA_W-1:0] payload;
    logic [NUM_CH-1:0] in_ready_c;

    nbyone_mux_rr_arb #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req     (bus.in_valid),
        .ptr     (rr_ptr_q),
        .gnt_vld (arb_vld),
        .gnt_idx (arb_idx)
    );

    // A select index beyond the last channel can only occur when NUM_CH is not a power of two.
    if ((1 << SEL_W) == NUM_CH) begin : g_sel_full
        assign sel_ok = 1'b1;
    end else begin : g_sel_part
        assign sel_ok = (32'(sel) < 32'(NUM_CH));
    end

    always_comb begin
        load_en    = rst_n & (~out_valid_q | bus.out_ready);
        gnt_vld    = 1'b0;
        gnt_idx    = '0;
        if (mode == MODE_RR) begin
            gnt_vld = arb_vld;
            gnt_idx = arb_idx;
        end else begin
            gnt_vld = sel_ok;
            gnt_idx = sel;
        end

        in_ready_c = '0;
        if (gnt_vld) begin
            in_ready_c[gnt_idx] = load_en;
        end

        xfer    = gnt_vld & load_en & bus.in_valid[gnt_idx];
        payload = bus.in_data[gnt_idx*DATA_W +: DATA_W];

        out_valid_d = load_en ? xfer : out_valid_q;
        out_data_d  = xfer ? payload : out_data_q;
        out_ch_d    = xfer ? gnt_idx : out_ch_q;

        // Pointer moves past the winner only on a round-robin transfer.
        rr_ptr_d = rr_ptr_q;
        if ((mode == MODE_RR) && xfer) begin
            rr_ptr_d = (32'(gnt_idx) == 32'(NUM_CH - 1)) ? '0 : gnt_idx + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

`ifdef NBYONE_MUX_PARITY_EN
    logic out_parity_q, out_parity_d;

    always_comb begin
        out_parity_d = xfer ? ^payload : out_parity_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_parity_q <= 1'b0;
        end else begin
            out_parity_q <= out_parity_d;
        end
    end

    assign bus.out_parity = out_parity_q;
`else
    assign bus.out_parity = 1'b0;
`endif

    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;

endmodule
